// File: rtl/uart_pkg.sv
// Shared definitions for the UART block: state codes, frame width, line level.
package uart_pkg;

    // Frame payload width.
    localparam int DATA_BITS = 8;

    // Level of an idle serial line (and of a good stop bit).
    localparam logic LINE_IDLE = 1'b1;

    // Receiver state codes. The low four line up with the transmitter's
    // 2-bit codes so both sides decode the same frame phase identically.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STOP    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        START   = ST_START,
        DATA    = ST_DATA,
        STOP    = ST_STOP,
        RECOVER = ST_RECOVER
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte and status pulses out.
interface uart_rx_if;

    logic                           rx_in;
    logic [uart_pkg::DATA_BITS-1:0] rx_data;
    logic                           rx_valid;
    logic                           frame_err;
    logic                           start;
    logic                           busy;

    // The receiver itself.
    modport master (
        input  rx_in,
        output rx_data,
        output rx_valid,
        output frame_err,
        output start,
        output busy
    );

    // Whoever drives the line and consumes the received bytes.
    modport slave (
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  start,
        input  busy
    );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous serial line. Resets to the
// idle level so a freshly reset receiver never sees a phantom start bit.
module uart_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw line through the chain; the oldest stage is the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{LINE_IDLE}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the line, validates the start bit at mid-bit,
// shifts in 8 data bits LSB first and checks the stop bit. Emits one-cycle
// start / rx_valid / frame_err pulses; rx_data holds the last good byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    // Offset within a bit at which the line is sampled.
    localparam logic [CNT_W-1:0]  HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_s;

    rx_state_e            state_q;
    logic [CNT_W-1:0]     clk_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 start_q;
    logic                 busy_q;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.rx_in),
        .q_o   (rx_s)
    );

    // Frame FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            start_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_s != LINE_IDLE) begin
                        if (HALF == '0) begin
                            // Mid-bit of the start bit is right now.
                            state_q   <= DATA;
                            clk_cnt_q <= '0;
                            start_q   <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            // This cycle is offset 0 of the start bit.
                            state_q   <= START;
                            clk_cnt_q <= CNT_W'(1);
                        end
                    end
                end
                START: begin
                    if (rx_s == LINE_IDLE) begin
                        // Low pulse shorter than half a bit: glitch.
                        state_q   <= IDLE;
                        clk_cnt_q <= '0;
                    end else if (clk_cnt_q == HALF) begin
                        state_q   <= DATA;
                        clk_cnt_q <= '0;
                        start_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_q == LAST) begin
                        shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        clk_cnt_q <= '0;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_q == LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s == LINE_IDLE) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            // Bad stop bit: keep the previous byte visible.
                            frame_err_q <= 1'b1;
                            state_q     <= RECOVER;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RECOVER: begin
                    // A held-low line (break) must release before we re-arm.
                    if (rx_s == LINE_IDLE) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.start     = start_q;
    assign bus.busy      = busy_q;

endmodule
